// File: rtl/coco3_clk_pkg.sv
// CoCo3 clock-enable generator shared types and constants.
// Sequencer states, E/Q periods and the E/Q phase decoder.
package coco3_clk_pkg;

  typedef enum logic [1:0] {
    HOLD,
    WAIT,
    RUN
  } seq_state_e;

  localparam int unsigned E_PERIOD_SLOW = 64;
  localparam int unsigned E_PERIOD_FAST = 32;
  localparam int unsigned SYS_CLK_HZ    = 57272727;

  // E is the upper half of the period, Q is offset a quarter ahead.
  function automatic logic [1:0] eq_level(
    input logic [5:0] p,
    input logic       fast
  );
    logic e;
    logic q;
    if (fast) begin
      e = p[4];
      q = p[4] ^ p[3];
    end else begin
      e = p[5];
      q = p[5] ^ p[4];
    end
    return {e, q};
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for single-bit async inputs.
// Resets to 0 so lock and turbo read as inactive.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/coco3_clk_en_gen.sv
// CoCo3 reset sequencer and clock-enable generator.
// Holds the core in reset until PLL lock is stable, then runs enables and E/Q.
module coco3_clk_en_gen
  import coco3_clk_pkg::*;
#(
  parameter int unsigned LOCK_WAIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pll_locked,
  input  logic turbo,
  output logic sys_rst_n,
  output logic ce_28m,
  output logic ce_14m,
  output logic ce_3m58,
  output logic cpu_e,
  output logic cpu_q,
  output logic ce_e_rise,
  output logic ce_e_fall,
  output logic turbo_active
);

  localparam int unsigned CW = $clog2(LOCK_WAIT);

  logic lock_s;
  logic turbo_s;

  sync2 u_sync_lock (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (pll_locked),
    .q    (lock_s)
  );

  sync2 u_sync_turbo (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (turbo),
    .q    (turbo_s)
  );

  seq_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    div_q, div_d;
  logic [5:0]    p_q, p_d;
  logic          sys_rst_n_q, sys_rst_n_d;
  logic          ce_28m_q, ce_28m_d;
  logic          ce_14m_q, ce_14m_d;
  logic          ce_3m58_q, ce_3m58_d;
  logic          cpu_e_q, cpu_e_d;
  logic          cpu_q_q, cpu_q_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          turbo_q, turbo_d;

  // Lock sequencer: HOLD until lock, WAIT for a stable window, then RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      HOLD: begin
        if (lock_s) state_d = WAIT;
      end
      WAIT: begin
        if (!lock_s) begin
          state_d = HOLD;
        end else if (cnt_q == CW'(LOCK_WAIT - 1)) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) state_d = HOLD;
      end
      default: state_d = HOLD;
    endcase
  end

  logic       run_q;
  logic       run_d;
  logic       adv;
  logic       sw;
  logic [5:0] last;
  logic [1:0] eq_d;

  // Divider, E/Q phase and rate switch; a switch holds p at 0 one extra cycle.
  always_comb begin
    run_q = (state_q == RUN);
    run_d = (state_d == RUN);
    adv   = run_q && run_d;
    div_d = adv ? div_q + 6'd1 : 6'd0;
    sw    = run_q && fall_q && (turbo_s != turbo_q);
    turbo_d = sw ? turbo_s : turbo_q;
    last  = turbo_q ? 6'(E_PERIOD_FAST - 1) : 6'(E_PERIOD_SLOW - 1);
    if (!adv || sw) begin
      p_d = 6'd0;
    end else if (p_q == last) begin
      p_d = 6'd0;
    end else begin
      p_d = p_q + 6'd1;
    end
    eq_d        = eq_level(p_d, turbo_d);
    sys_rst_n_d = run_d;
    ce_28m_d    = run_d && div_d[0];
    ce_14m_d    = run_d && (&div_d[1:0]);
    ce_3m58_d   = run_d && (&div_d[3:0]);
    cpu_e_d     = run_d && eq_d[1];
    cpu_q_d     = run_d && eq_d[0];
    rise_d      = cpu_e_d && !cpu_e_q;
    fall_d      = run_d && !cpu_e_d && cpu_e_q;
  end

  // All state and outputs register here; async reset clears them at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HOLD;
      cnt_q       <= '0;
      div_q       <= '0;
      p_q         <= '0;
      sys_rst_n_q <= 1'b0;
      ce_28m_q    <= 1'b0;
      ce_14m_q    <= 1'b0;
      ce_3m58_q   <= 1'b0;
      cpu_e_q     <= 1'b0;
      cpu_q_q     <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      turbo_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      p_q         <= p_d;
      sys_rst_n_q <= sys_rst_n_d;
      ce_28m_q    <= ce_28m_d;
      ce_14m_q    <= ce_14m_d;
      ce_3m58_q   <= ce_3m58_d;
      cpu_e_q     <= cpu_e_d;
      cpu_q_q     <= cpu_q_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      turbo_q     <= turbo_d;
    end
  end

  assign sys_rst_n    = sys_rst_n_q;
  assign ce_28m       = ce_28m_q;
  assign ce_14m       = ce_14m_q;
  assign ce_3m58      = ce_3m58_q;
  assign cpu_e        = cpu_e_q;
  assign cpu_q        = cpu_q_q;
  assign ce_e_rise    = rise_q;
  assign ce_e_fall    = fall_q;
  assign turbo_active = turbo_q;

endmodule
